skid_stage: RTL and testbench
=============================

// Module: skid_stage
// PURPOSE
//  Registered valid/ready pipeline stage with 2-entry skid buffering.
//  Captures the WIDTH-bit result of a bit-sliced gate array (Nor2/Nand2 style) and presents it downstream.
//  Breaks the combinational path and makes in_ready a registered signal, at full 1-word/cycle throughput.
//  Sits directly downstream of the library gate arrays in the datapath.
// PARAMETERS
//  WIDTH     1   data width in bits; must be >= 1
//  DATA_RST  0   value loaded into both data registers on rst/flush (WIDTH bits)
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      synchronous reset, active-high
//  flush      in   1      synchronous clear of buffered contents, active-high
//  in_valid   in   1      upstream word valid
//  in_ready   out  1      stage can accept a word this cycle
//  in_data    in   WIDTH  upstream word (gate-array output)
//  out_valid  out  1      out_data valid
//  out_ready  in   1      downstream accepts out_data this cycle
//  out_data   out  WIDTH  buffered word; driven from main register only
//  count      out  2      occupancy 0..2
// BEHAVIOUR
//  Definitions:
//   - in_fire  = in_valid & in_ready; out_fire = out_valid & out_ready.
//   - Storage: main reg (drives out_data) and skid reg.
//  States (also = count): EMPTY=0, ONE=1, FULL=2. Transitions:
//   - EMPTY + in_fire           -> main<=in_data, ONE
//   - ONE + in_fire & out_fire  -> main<=in_data, ONE
//   - ONE + in_fire only        -> skid<=in_data, FULL
//   - ONE + out_fire only       -> EMPTY
//   - FULL + out_fire           -> main<=skid, ONE
//   - in_fire cannot occur in FULL.
//  Handshake and ordering:
//   - in_ready = (state != FULL) & ~rst, registered state only; no combinational path from out_ready to in_ready.
//   - out_valid = (state != EMPTY); out_data holds stable while out_valid & ~out_ready.
//   - Words exit in arrival order; none dropped or duplicated.
//  Latency and throughput:
//   - Latency: in_fire at cycle N -> out_valid with that word at N+1 when EMPTY.
//   - Throughput: 1 word/cycle sustained with out_ready held high.
//  Reset and flush:
//   - rst (sync): state EMPTY, out_valid=0, in_ready=0 while rst high and 1 the cycle after, count=0, main/skid=DATA_RST.
//   - flush: same clear as rst, but in_ready is unaffected. It has priority over in_fire/out_fire in the same cycle, and the accepted/offered words are discarded.
//   - rst mid-transfer discards everything; no partial state survives.
//   - rst has priority over flush.
//  X handling: in_data is ignored when ~in_fire; upstream must hold in_data stable while in_valid & ~in_ready.
// CONFIGURATION
//  SKID_STAGE_PARITY_EN defined:
//   - Adds in_par (in, 1) and out_par_err (out, 1).
//   - Each entry stores the parity bit beside its data.
//   - out_par_err = out_valid & (^out_data ^ stored_par), combinational from regs.
//   - Parity regs reset/flush to ^DATA_RST.
//  Not defined: no parity ports or registers; behaviour otherwise identical.
// TESTING
//  - rst=1 for 2 cycles -> out_valid=0, count=0, in_ready=0 during rst, in_ready=1 next cycle.
//  - Single word: in_data=8'hA5 (WIDTH=8) with out_ready=1 -> out_valid=1 and out_data=A5 exactly one cycle later.
//  - Stream 0..15 with out_ready=1 -> 16 words out in order, no bubbles, count stays 1.
//  - out_ready=0, push 8'h11 then 8'h22 -> count=2, in_ready=0; release -> 11 then 22.
//  - FULL + flush=1 with out_ready=1 -> next cycle count=0, out_valid=0, no word delivered.
//  - PARITY_EN: push 8'h03 with in_par=1 (wrong) -> out_par_err=1 while word presented; in_par=0 -> 0.

Source files
------------

// File: rtl/skid_stage.sv
// rtl/skid_stage.sv - registered valid/ready stage with 2-entry skid buffer (option: SKID_STAGE_PARITY_EN)
module skid_stage #(
   parameter int               WIDTH    = 1,
   parameter logic [WIDTH-1:0] DATA_RST = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
`ifdef SKID_STAGE_PARITY_EN
   ,
   input  logic             in_par,
   output logic             out_par_err
`endif
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] main_q;
   logic [WIDTH-1:0] skid_q;
   logic             in_fire;
   logic             out_fire;
   logic             load_main_in;
   logic             load_main_skid;
   logic             load_skid;

   // in_ready depends only on registered state (plus rst), never on out_ready
   assign in_ready  = (state != FULL) & ~rst;
   assign out_valid = (state != EMPTY);
   assign out_data  = main_q;
   assign count     = state;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   // next-state and register load selects
   always_comb begin
      state_next     = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         EMPTY: begin
            if (in_fire) begin
               load_main_in = 1'b1;
               state_next   = ONE;
            end
         end
         ONE: begin
            if (in_fire && out_fire) begin
               load_main_in = 1'b1;
            end else if (in_fire) begin
               load_skid  = 1'b1;
               state_next = FULL;
            end else if (out_fire) begin
               state_next = EMPTY;
            end
         end
         FULL: begin
            if (out_fire) begin
               load_main_skid = 1'b1;
               state_next     = ONE;
            end
         end
         default: state_next = EMPTY;
      endcase
   end

   // state register; rst and flush both clear everything, discarding same-cycle handshakes
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // data registers: main always drives out_data, skid only holds the overflow word
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_q <= DATA_RST;
         skid_q <= DATA_RST;
      end else begin
         if (load_main_in) begin
            main_q <= in_data;
         end else if (load_main_skid) begin
            main_q <= skid_q;
         end
         if (load_skid) begin
            skid_q <= in_data;
         end
      end
   end

`ifdef SKID_STAGE_PARITY_EN
   logic main_par_q;
   logic skid_par_q;

   // parity bits travel beside their data words
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_par_q <= ^DATA_RST;
         skid_par_q <= ^DATA_RST;
      end else begin
         if (load_main_in) begin
            main_par_q <= in_par;
         end else if (load_main_skid) begin
            main_par_q <= skid_par_q;
         end
         if (load_skid) begin
            skid_par_q <= in_par;
         end
      end
   end

   assign out_par_err = out_valid & (^main_q ^ main_par_q);
`endif

endmodule

// File: tb/tb_skid_stage.sv
// tb/tb_skid_stage.sv - directed-vector bench for skid_stage (option: SKID_STAGE_PARITY_EN)
module tb_skid_stage;

   localparam int         WIDTH    = 8;
   localparam logic [7:0] DATA_RST = 8'h5A;

   logic             clk = 1'b0;
   logic             rst;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [1:0]       count;
`ifdef SKID_STAGE_PARITY_EN
   logic             in_par;
   logic             out_par_err;
`endif

   int vectors = 0;
   int miscompares = 0;

   skid_stage #(.WIDTH(WIDTH), .DATA_RST(DATA_RST)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
`ifdef SKID_STAGE_PARITY_EN
      ,
      .in_par      (in_par),
      .out_par_err (out_par_err)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [7:0] d);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
`ifdef SKID_STAGE_PARITY_EN
      in_par    = 1'b0;
`endif

      // reset held for two edges
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", in_ready, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_count", count, 0);
      check("rst_data", out_data, 8'h5A);
      rst = 1'b0;
      #1 check("post_rst_in_ready", in_ready, 1);

      // single word, one-cycle latency
      push(8'hA5);
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("single_valid", out_valid, 1);
      check("single_data", out_data, 8'hA5);
      check("single_count", count, 1);
      @(negedge clk);
      check("single_drain_valid", out_valid, 0);
      check("single_drain_count", count, 0);

      // stream 0..15 at full rate
      for (int i = 0; i <= 16; i++) begin
         @(negedge clk);
         if (i > 0) begin
            check($sformatf("stream_valid_%0d", i - 1), out_valid, 1);
            check($sformatf("stream_data_%0d", i - 1), out_data, i - 1);
            check($sformatf("stream_count_%0d", i - 1), count, 1);
         end
         if (i < 16) begin
            in_valid = 1'b1;
            in_data  = i[7:0];
         end else begin
            in_valid = 1'b0;
         end
      end
      @(negedge clk);
      check("stream_end_count", count, 0);

      // backpressure fills skid, release drains in order
      out_ready = 1'b0;
      push(8'h11);
      push(8'h22);
      @(negedge clk);
      in_valid = 1'b0;
      check("full_count", count, 2);
      check("full_in_ready", in_ready, 0);
      check("full_data_hold", out_data, 8'h11);
      @(negedge clk);
      check("full_stable", out_data, 8'h11);
      out_ready = 1'b1;
      @(negedge clk);
      check("drain_first_seen", count, 1);
      check("drain_second", out_data, 8'h22);
      check("drain_in_ready", in_ready, 1);
      @(negedge clk);
      check("drain_empty", count, 0);

      // flush in FULL with downstream ready: nothing delivered
      out_ready = 1'b0;
      push(8'h33);
      push(8'h44);
      @(negedge clk);
      in_valid  = 1'b0;
      check("pre_flush_count", count, 2);
      flush     = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_full_count", count, 0);
      check("flush_full_valid", out_valid, 0);
      check("flush_full_data", out_data, 8'h5A);
      @(negedge clk);
      check("flush_full_still_empty", out_valid, 0);

      // flush beats simultaneous in_fire/out_fire in ONE
      out_ready = 1'b0;
      push(8'h66);
      @(negedge clk);
      check("pre_flush_one", count, 1);
      in_data   = 8'h77;
      out_ready = 1'b1;
      flush     = 1'b1;
      #1 check("flush_in_ready", in_ready, 1);
      @(negedge clk);
      flush    = 1'b0;
      in_valid = 1'b0;
      check("flush_prio_count", count, 0);
      check("flush_prio_valid", out_valid, 0);

      // reset mid-transfer while FULL
      out_ready = 1'b0;
      push(8'h88);
      push(8'h99);
      @(negedge clk);
      in_valid = 1'b0;
      rst      = 1'b1;
      #1 check("mid_rst_in_ready", in_ready, 0);
      @(negedge clk);
      check("mid_rst_count", count, 0);
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_in_ready_hold", in_ready, 0);
      rst = 1'b0;
      #1 check("mid_rst_release", in_ready, 1);

`ifdef SKID_STAGE_PARITY_EN
      // wrong parity flagged while presented, correct parity clean
      out_ready = 1'b0;
      in_par    = 1'b1;
      push(8'h03);
      @(negedge clk);
      in_valid = 1'b0;
      check("par_err_bad", out_par_err, 1);
      out_ready = 1'b1;
      @(negedge clk);
      check("par_err_idle", out_par_err, 0);
      out_ready = 1'b0;
      in_par    = 1'b0;
      push(8'h03);
      @(negedge clk);
      in_valid = 1'b0;
      check("par_err_good", out_par_err, 0);
      out_ready = 1'b1;
      @(negedge clk);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
